cookie_loader: RTL
==================

# cookie_loader

Upstream sequencer for the `cookie` 16×16 life grid. It accepts a frame of 16 row words over a valid/ready stream and serializes them into the grid's load chain (`input_bit` with `en`). It then issues a programmed number of generation steps (`en` + `run`) and a one-cycle `display` pulse. Finally it reports completion, so the downstream display chain can be drained.

## Interface
Parameters:
- `GRID_W`, 16, row width in cells (bits per word)
- `GRID_H`, 16, rows per frame
- `GEN_W`, 8, width of generation count

Ports:
- `clk`  in  1  system clock, all logic rising-edge
- `rst_n`  in  1  asynchronous active-low reset
- `s_data`  in  GRID_W  row word
- `s_valid`  in  1  row word valid
- `s_ready`  out  1  row word accepted when `s_valid & s_ready` at a rising edge
- `gen_count`  in  GEN_W  generations to run; sampled on acceptance of a frame's first word
- `abort`  in  1  synchronous frame abort
- `en`  out  1  to `cookie.en`
- `run`  out  1  to `cookie.run`
- `display`  out  1  to `cookie.display`
- `input_bit`  out  1  to `cookie.input_bit`
- `busy`  out  1  high whenever state ≠ IDLE
- `frame_done`  out  1  one-cycle pulse at end of frame

## Operation
- Grid contract (decided): `en=1,run=0` shifts the load chain one position; `en=1,run=1` advances one generation; `display=1` (with `en=0`) captures state into the display chain.
- Bit mapping: after 256 shifts the first bit shifted sits at cell 255. Row words therefore arrive row 15 first, row 0 last. Within a word, bit 15 (column 15) is shifted first and bit 0 last. Result: `s_data[c]` of row r lands at cell r*16+c.
- States: IDLE → LOAD → RUN → SHOW → DONE → IDLE.
- IDLE: `s_ready=1`. On acceptance, latch the word and `gen_count`, set rows_left=15, and go to LOAD.
- LOAD: 16 shift cycles per word, with `en=1`, `run=0`, `input_bit` = word bit 15−k on cycle k.
  - `s_ready=1` only on shift cycle k=15 while rows_left>0. Acceptance on that edge gives zero-bubble streaming.
  - If `s_valid` is low at that point, the shifter empties: `en=0`, `input_bit` holds its last value, and `s_ready` stays 1 until a word arrives.
  - After the last bit of row 0: go to RUN if the latched gens>0, else to SHOW.
- RUN: `en=1`, `run=1` for exactly gens consecutive cycles, using an internal down-counter.
- SHOW: exactly one cycle of `display=1`, `en=0`, `run=0`.
- DONE: `frame_done=1` for one cycle, then IDLE.
- `abort` (any state ≠ IDLE): next cycle the block is in IDLE, with all strobes low, counters cleared, and no `frame_done`. Partial grid contents are left as-is. `abort` in IDLE is ignored.
- `gen_count` changes after latching have no effect on the current frame.

## Timing
- Reset values: `en=0`, `run=0`, `display=0`, `input_bit=0`, `frame_done=0`, `busy=0`, `s_ready=0`.
  - `s_ready` is registered. It rises on the first edge after `rst_n` deasserts.
- All outputs are registered, so there are no combinational paths from inputs to outputs.
- Latency: the first word is accepted at edge T; its first bit is on `input_bit` with `en=1` during cycle T+1.
- Continuous frame: the frame occupies 256 `en` cycles, then gens RUN cycles, then 1 SHOW cycle, then 1 DONE cycle.
- Reset asserted mid-operation: outputs go to their reset values immediately (async), and the partial frame is discarded.
- Simultaneous `abort` and acceptance on the same edge: `abort` wins and the word is dropped.
- gens = 2^GEN_W−1 must run the full count, with no wrap.

## Structure
- `cookie_pkg` holds `GRID_W`, `GRID_H`, `CELLS=GRID_W*GRID_H`, and the `loader_state_t` enum (IDLE, LOAD, RUN, SHOW, DONE).
- One sub-module, `row_serializer`: a 16-bit parallel-in/serial-out register.
  - Inputs: `load`, `shift`, and a bit counter.
  - Outputs: `last_bit` and `empty` flags.
- The FSM, row counter and generation counter live in `cookie_loader`.

## Test plan
- Reset release: all outputs are 0 during reset; `s_ready` is 1 one cycle after release and `busy` is 0.
- Single glider frame with `gen_count=0`, words streamed back-to-back:
  - Exactly 256 consecutive `en=1,run=0` cycles.
  - `input_bit` sequence is the rows reversed, MSB-first.
  - Then `display` high for 1 cycle, then `frame_done` high for 1 cycle.
  - Compared against the `cookie` model: cells match the input.
- Blinker frame with `gen_count=4`: 4 `run` cycles follow the load, and the displayed state equals the original blinker phase.
- `s_valid` dropped for 5 cycles after row 7: `en` is low for exactly those stall cycles, no bits are lost, and the loaded grid is still correct.
- `abort` asserted on cycle 100 of LOAD: the next cycle shows IDLE, `busy=0`, and no `frame_done`. A following full frame loads correctly.
- `gen_count=255`, with `gen_count` changed to 3 mid-load: exactly 255 `run` cycles are issued.

Source files
------------

// File: rtl/cookie_pkg.sv
// Shared constants and state type for the cookie grid loader.
package cookie_pkg;

    localparam int GRID_W = 16;               // cells per row, bits per row word
    localparam int GRID_H = 16;               // rows per frame
    localparam int CELLS  = GRID_W * GRID_H;  // length of the grid load chain

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        SHOW,
        DONE
    } loader_state_t;

endpackage

// File: rtl/cookie_loader_row_serializer.sv
// Parallel-in / serial-out register for one row word, MSB shifted first.
// The serial output is the top flop itself, so it is a registered output,
// and it keeps the last bit once the word has been fully shifted out.
module row_serializer
    import cookie_pkg::*;
#(
    parameter int W  = GRID_W,
    parameter int CW = $clog2(W)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,       // capture a new word
    input  logic          shift,      // advance to the next bit
    input  logic          flush,      // drop the current word (abort)
    input  logic [W-1:0]  data,
    input  logic [CW-1:0] bit_cnt,    // index of the bit currently on serial_out
    output logic          serial_out,
    output logic          last_bit,   // current bit is the word's final bit
    output logic          empty       // no word pending
);

    logic [W-1:0] shreg;

    assign last_bit   = (bit_cnt == CW'(W - 1));
    assign serial_out = shreg[W-1];

    // Word register and empty flag; a shift on the last bit empties instead of shifting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses <= so every flop samples pre-edge values.
            shreg <= '0;
            empty <= 1'b1;
        end else if (flush) begin
            empty <= 1'b1;
        end else if (load) begin
            shreg <= data;
            empty <= 1'b0;
        end else if (shift) begin
            if (last_bit) begin
                empty <= 1'b1;
            end else begin
                shreg <= {shreg[W-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/cookie_loader.sv
// Frame sequencer for the cookie life grid: streams 16 row words into the
// grid's load chain, runs a latched number of generations, pulses display,
// then reports frame completion. Every output comes straight from a flop.
module cookie_loader
    import cookie_pkg::loader_state_t, cookie_pkg::IDLE, cookie_pkg::LOAD,
           cookie_pkg::RUN, cookie_pkg::SHOW, cookie_pkg::DONE;
#(
    parameter int GRID_W = cookie_pkg::GRID_W,
    parameter int GRID_H = cookie_pkg::GRID_H,
    parameter int GEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [GRID_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [GEN_W-1:0]  gen_count,
    input  logic              abort,
    output logic              en,
    output logic              run,
    output logic              display,
    output logic              input_bit,
    output logic              busy,
    output logic              frame_done
);

    localparam int BIT_W = $clog2(GRID_W);
    localparam int ROW_W = $clog2(GRID_H);

    loader_state_t    state_q, state_n;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_n;
    logic [ROW_W-1:0] rows_left_q, rows_left_n;
    logic [GEN_W-1:0] gen_left_q, gen_left_n;

    logic en_n, run_n, display_n, frame_done_n, s_ready_n, busy_n;
    logic ser_load, ser_shift, ser_flush, ser_last, ser_empty;
    logic accept, load_slot;

    // s_ready is registered, so a handshake is just the two sampled flags.
    assign accept    = s_valid & s_ready;
    // A new word may enter when the shifter is empty or on its last bit,
    // provided rows remain in this frame.
    assign load_slot = (state_q == LOAD) && (rows_left_q != '0) && (ser_empty || ser_last);
    assign busy_n    = (state_n != IDLE);

    row_serializer #(
        .W  (GRID_W),
        .CW (BIT_W)
    ) u_row_serializer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (ser_load),
        .shift      (ser_shift),
        .flush      (ser_flush),
        .data       (s_data),
        .bit_cnt    (bit_cnt_q),
        .serial_out (input_bit),
        .last_bit   (ser_last),
        .empty      (ser_empty)
    );

    // Next state, counters and next-cycle output values.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_n      = state_q;
        bit_cnt_n    = bit_cnt_q;
        rows_left_n  = rows_left_q;
        gen_left_n   = gen_left_q;
        ser_load     = 1'b0;
        ser_shift    = 1'b0;
        ser_flush    = 1'b0;
        en_n         = 1'b0;
        run_n        = 1'b0;
        display_n    = 1'b0;
        frame_done_n = 1'b0;
        s_ready_n    = 1'b0;

        if (abort && (state_q != IDLE)) begin
            // Abort beats a same-edge acceptance: the word is never loaded.
            state_n     = IDLE;
            bit_cnt_n   = '0;
            rows_left_n = '0;
            gen_left_n  = '0;
            ser_flush   = 1'b1;
            s_ready_n   = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    s_ready_n = 1'b1;
                    if (accept) begin
                        ser_load    = 1'b1;
                        bit_cnt_n   = '0;
                        rows_left_n = ROW_W'(GRID_H - 1);
                        gen_left_n  = gen_count;
                        state_n     = LOAD;
                        en_n        = 1'b1;
                        s_ready_n   = 1'b0;
                    end
                end

                LOAD: begin
                    if (load_slot) begin
                        if (accept) begin
                            ser_load    = 1'b1;
                            bit_cnt_n   = '0;
                            rows_left_n = rows_left_q - ROW_W'(1);
                            en_n        = 1'b1;
                        end else begin
                            // Starved: drain the shifter and keep asking for a word.
                            ser_shift = !ser_empty;
                            bit_cnt_n = '0;
                            s_ready_n = 1'b1;
                        end
                    end else if (!ser_last) begin
                        ser_shift = 1'b1;
                        bit_cnt_n = bit_cnt_q + BIT_W'(1);
                        en_n      = 1'b1;
                        s_ready_n = (bit_cnt_q == BIT_W'(GRID_W - 2)) && (rows_left_q != '0);
                    end else begin
                        // Last bit of row 0 is on the chain this cycle.
                        ser_shift = 1'b1;
                        bit_cnt_n = '0;
                        if (gen_left_q != '0) begin
                            state_n = RUN;
                            en_n    = 1'b1;
                            run_n   = 1'b1;
                        end else begin
                            state_n   = SHOW;
                            display_n = 1'b1;
                        end
                    end
                end

                RUN: begin
                    // gen_left_q counts the current run cycle too.
                    if (gen_left_q > GEN_W'(1)) begin
                        gen_left_n = gen_left_q - GEN_W'(1);
                        en_n       = 1'b1;
                        run_n      = 1'b1;
                    end else begin
                        gen_left_n = '0;
                        state_n    = SHOW;
                        display_n  = 1'b1;
                    end
                end

                SHOW: begin
                    state_n      = DONE;
                    frame_done_n = 1'b1;
                end

                DONE: begin
                    state_n   = IDLE;
                    s_ready_n = 1'b1;
                end

                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            rows_left_q <= '0;
            gen_left_q  <= '0;
            en          <= 1'b0;
            run         <= 1'b0;
            display     <= 1'b0;
            frame_done  <= 1'b0;
            s_ready     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state_q     <= state_n;
            bit_cnt_q   <= bit_cnt_n;
            rows_left_q <= rows_left_n;
            gen_left_q  <= gen_left_n;
            en          <= en_n;
            run         <= run_n;
            display     <= display_n;
            frame_done  <= frame_done_n;
            s_ready     <= s_ready_n;
            busy        <= busy_n;
        end
    end

endmodule
